// File: rtl/gen_clock_multi.sv
// Multi-channel glitch-free programmable clock divider with global phase-align sync.
// Optional GEN_CLOCK_MULTI_STROBE_EN adds a ce_rise pulse per channel on each rising toggle.
//
// state       | meaning
// ------------|------------------------------------------------------------
// ST_IDLE     | counter held at 0, clock_out low, pending limit applied at once
// ST_RUN      | counter counts 0..lim_act, toggles clock_out at the limit
// ST_STOPPING | still running; drops to ST_IDLE at the next falling toggle
module gen_clock_multi #(
   parameter int               NUM_CH    = 4,
   parameter int               CNT_W     = 16,
   parameter logic [CNT_W-1:0] LIM_RESET = '0,
   localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock_in,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_lim,
   output logic [NUM_CH-1:0] cfg_pend,
   output logic [NUM_CH-1:0] clock_out
`ifdef GEN_CLOCK_MULTI_STROBE_EN
   ,
   output logic [NUM_CH-1:0] ce_rise
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } ch_state_t;

   ch_state_t        state    [NUM_CH];
   logic [CNT_W-1:0] cnt      [NUM_CH];
   logic [CNT_W-1:0] lim_act  [NUM_CH];
   logic [CNT_W-1:0] lim_pend [NUM_CH];

   logic [NUM_CH-1:0] wr_hit;
   logic [NUM_CH-1:0] tgl;
   logic [NUM_CH-1:0] apply;

   // Out-of-range channel indices simply match no channel, so the write is dropped.
   always_comb begin
      wr_hit = '0;
      tgl    = '0;
      apply  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i] = cfg_we && (int'(cfg_ch) == i);
         tgl[i]    = (state[i] != ST_IDLE) && (cnt[i] >= lim_act[i]);
         apply[i]  = (state[i] == ST_IDLE) || sync || tgl[i];
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cfg_pend  <= '0;
         clock_out <= '0;
`ifdef GEN_CLOCK_MULTI_STROBE_EN
         ce_rise   <= '0;
`endif
         for (int i = 0; i < NUM_CH; i++) begin
            state[i]    <= ST_IDLE;
            cnt[i]      <= '0;
            lim_act[i]  <= LIM_RESET;
            lim_pend[i] <= LIM_RESET;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
`ifdef GEN_CLOCK_MULTI_STROBE_EN
            ce_rise[i] <= 1'b0;
`endif
            if (wr_hit[i]) lim_pend[i] <= cfg_lim;
            // A write landing on an apply cycle keeps cfg_pend set for the next boundary.
            cfg_pend[i] <= wr_hit[i] | (cfg_pend[i] & ~apply[i]);
            if (apply[i] && cfg_pend[i]) lim_act[i] <= lim_pend[i];

            if (state[i] == ST_IDLE) begin
               cnt[i]       <= '0;
               clock_out[i] <= 1'b0;
               if (ch_en[i]) state[i] <= ST_RUN;
            end else if (sync) begin
               cnt[i]       <= '0;
               clock_out[i] <= 1'b0;
               if (state[i] == ST_STOPPING || !ch_en[i]) state[i] <= ST_IDLE;
               else                                      state[i] <= ST_RUN;
            end else if (tgl[i]) begin
               cnt[i]       <= '0;
               clock_out[i] <= ~clock_out[i];
`ifdef GEN_CLOCK_MULTI_STROBE_EN
               ce_rise[i]   <= ~clock_out[i];
`endif
               if (!ch_en[i] && clock_out[i]) state[i] <= ST_IDLE;
               else if (ch_en[i])              state[i] <= ST_RUN;
               else                            state[i] <= ST_STOPPING;
            end else begin
               cnt[i]   <= cnt[i] + 1'b1;
               state[i] <= ch_en[i] ? ST_RUN : ST_STOPPING;
            end
         end
      end
   end

endmodule

// File: tb/tb_gen_clock_multi.sv
// Directed bench for gen_clock_multi: vector table plus hand-written multi-cycle sequences.
// Exercises the ce_rise strobe when built with GEN_CLOCK_MULTI_STROBE_EN.
module tb_gen_clock_multi;

   logic        clock_in = 1'b0;
   logic        reset_n  = 1'b0;
   logic [3:0]  ch_en    = '0;
   logic        sync     = 1'b0;
   logic        cfg_we   = 1'b0;
   logic [1:0]  cfg_ch   = '0;
   logic [15:0] cfg_lim  = '0;
   logic [3:0]  cfg_pend;
   logic [3:0]  clock_out;

   logic [2:0]  ch_en3   = '0;
   logic        cfg_we3  = 1'b0;
   logic [1:0]  cfg_ch3  = '0;
   logic [2:0]  cfg_pend3;
   logic [2:0]  clock_out3;
`ifdef GEN_CLOCK_MULTI_STROBE_EN
   logic [3:0]  ce_rise;
   logic [2:0]  ce_rise3;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   gen_clock_multi #(.NUM_CH(4), .CNT_W(16), .LIM_RESET(16'd0)) u_dut (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .ch_en    (ch_en),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_lim  (cfg_lim),
      .cfg_pend (cfg_pend),
      .clock_out(clock_out)
`ifdef GEN_CLOCK_MULTI_STROBE_EN
      ,
      .ce_rise  (ce_rise)
`endif
   );

   // Three-channel instance so that an out-of-range channel index is representable.
   gen_clock_multi #(.NUM_CH(3), .CNT_W(16), .LIM_RESET(16'd0)) u_dut3 (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .ch_en    (ch_en3),
      .sync     (1'b0),
      .cfg_we   (cfg_we3),
      .cfg_ch   (cfg_ch3),
      .cfg_lim  (cfg_lim),
      .cfg_pend (cfg_pend3),
      .clock_out(clock_out3)
`ifdef GEN_CLOCK_MULTI_STROBE_EN
      ,
      .ce_rise  (ce_rise3)
`endif
   );

   always #5 clock_in = ~clock_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   typedef struct {
      logic [3:0]  en;
      logic        we;
      logic [1:0]  ch;
      logic [15:0] lim;
      logic [3:0]  clk;
      logic [3:0]  pend;
   } vec_t;

   vec_t tbl [30];

   initial begin
      int n, r0, r2;
      // ch0 at lim 0 (f/2); ch1 programmed to 3, then to 1 mid high phase; ch0 then stopped.
      tbl[0]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[2]  = '{4'b0001, 1'b1, 2'd1, 16'd3, 4'b0000, 4'b0010};
      tbl[3]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[4]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[5]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[6]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
      tbl[8]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
      tbl[9]  = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
      tbl[10] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
      tbl[11] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[12] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[13] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[14] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[15] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
      tbl[16] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
      tbl[17] = '{4'b0011, 1'b1, 2'd1, 16'd1, 4'b0011, 4'b0010};
      tbl[18] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0010};
      tbl[19] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[20] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[21] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
      tbl[22] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
      tbl[23] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000};
      tbl[24] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[25] = '{4'b0010, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000};
      tbl[26] = '{4'b0010, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
      tbl[27] = '{4'b0010, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[28] = '{4'b0010, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
      tbl[29] = '{4'b0010, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};

      repeat (3) step();
      check("reset clock_out", 32'(clock_out), 32'h0);
      check("reset cfg_pend", 32'(cfg_pend), 32'h0);
`ifdef GEN_CLOCK_MULTI_STROBE_EN
      check("reset ce_rise", 32'(ce_rise), 32'h0);
`endif
      @(negedge clock_in);
      reset_n = 1'b1;
      step();

      for (int v = 0; v < 30; v++) begin
         ch_en   = tbl[v].en;
         cfg_we  = tbl[v].we;
         cfg_ch  = tbl[v].ch;
         cfg_lim = tbl[v].lim;
         step();
         check($sformatf("vec%0d clk/pend", v), {24'h0, clock_out, cfg_pend},
               {24'h0, tbl[v].clk, tbl[v].pend});
      end
      cfg_we = 1'b0;

      // Drop enable mid high phase: phase completes, then output stays low.
      ch_en = 4'b0000;
      step();
      check("stop high kept", 32'(clock_out), 32'h2);
      step();
      check("stop fall", 32'(clock_out), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("stopped low %0d", k), 32'(clock_out), 32'h0);
      end
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_lim = 16'd3;
      step();
      cfg_we = 1'b0;
      check("idle write pend", 32'(cfg_pend), 32'h2);
      step();
      check("idle apply", 32'(cfg_pend), 32'h0);
      ch_en = 4'b0010;
      step();
      check("reenable low", 32'(clock_out[1]), 32'h0);
      n = 0;
      do begin
         step();
         n++;
      end while (!clock_out[1] && n < 20);
      check("reenable rise delay", n, 4);

      // Out-of-phase ch0 (lim 1) and ch2 (lim 5), then sync.
      ch_en = 4'b0000;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_lim = 16'd1;
      step();
      cfg_ch = 2'd2; cfg_lim = 16'd5;
      step();
      cfg_we = 1'b0;
      repeat (6) step();
      check("all idle", {28'h0, clock_out}, 32'h0);
      check("limits applied", {28'h0, cfg_pend}, 32'h0);
      ch_en = 4'b0100;
      repeat (3) step();
      ch_en = 4'b0101;
      repeat (7) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync low", 32'(clock_out), 32'h0);
      r0 = 0; r2 = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (clock_out[0] && r0 == 0) r0 = k;
         if (clock_out[2] && r2 == 0) r2 = k;
      end
      check("sync ch0 rise", r0, 2);
      check("sync ch2 rise", r2, 6);

      // Sync applies a pending limit at the sync edge.
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_lim = 16'd2;
      step();
      cfg_we = 1'b0;
      check("pend before sync", 32'(cfg_pend), 32'h4);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync clears pend", 32'(cfg_pend), 32'h0);
      check("sync2 low", 32'(clock_out), 32'h0);
      r0 = 0; r2 = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (clock_out[0] && r0 == 0) r0 = k;
         if (clock_out[2] && r2 == 0) r2 = k;
      end
      check("sync2 ch0 rise", r0, 2);
      check("sync2 ch2 rise new lim", r2, 3);

      // Out-of-range write is dropped; in-range write on the 3-channel instance lands.
      cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_lim = 16'd7;
      step();
      cfg_we3 = 1'b0;
      check("oob write ignored", 32'(cfg_pend3), 32'h0);
      cfg_we3 = 1'b1; cfg_ch3 = 2'd2;
      step();
      cfg_we3 = 1'b0;
      check("inrange write pend", 32'(cfg_pend3), 32'h4);
      step();
      check("dut3 idle output", 32'(clock_out3), 32'h0);

`ifdef GEN_CLOCK_MULTI_STROBE_EN
      begin
         logic [3:0] prev;
         prev = clock_out;
         for (int k = 0; k < 100; k++) begin
            if (k == 50) sync = 1'b1;
            step();
            sync = 1'b0;
            check($sformatf("ce_rise cyc%0d", k), 32'(ce_rise), 32'(clock_out & ~prev));
            prev = clock_out;
         end
      end
`endif

      // Asynchronous reset mid-run, between clock edges.
      n = 0;
      while (!clock_out[0] && n < 10) begin
         step();
         n++;
      end
      check("running before reset", 32'(clock_out[0]), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset clock_out", 32'(clock_out), 32'h0);
      check("async reset pend3", 32'(cfg_pend3), 32'h0);
      @(negedge clock_in);
      reset_n = 1'b1;
      ch_en = 4'b0001;
      step();
      check("post reset enable", 32'(clock_out), 32'h0);
      step();
      check("post reset lim lost hi", 32'(clock_out), 32'h1);
      step();
      check("post reset lim lost lo", 32'(clock_out), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
